// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_reg
// Brief    : N-channel valid/ready input mux with round-robin arbitration
//            (or forced channel select) feeding a single registered output.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module rr_mux_reg #(
  parameter  int width  = 32,
  parameter  int num_in = 16,
  localparam int sel_w  = $clog2(num_in)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [num_in-1:0]       in_valid,
  input  logic [num_in*width-1:0] in_data,
  output logic [num_in-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [sel_w-1:0]        force_sel,
  output logic                    out_valid,
  output logic [width-1:0]        out_data,
  output logic [sel_w-1:0]        out_sel,
  input  logic                    out_ready
);

  // Round-robin pointer: first channel examined by the search.
  logic [sel_w-1:0] ptr;

  logic             grant_valid;
  logic [sel_w-1:0] grant;
  logic             load_ok;
  logic             accept;
  int               idx;

  // Output register may take a new beat when empty or draining this cycle.
  assign load_ok = ~out_valid | out_ready;

  // Grant selection: forced channel, or first valid channel from ptr upward.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    if (force_en) begin
      // Loop compare keeps out-of-range force_sel values from ever matching.
      for (int i = 0; i < num_in; i++) begin
        if (force_sel == sel_w'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = sel_w'(i);
        end
      end
    end else begin
      for (int k = 0; k < num_in; k++) begin
        idx = int'(ptr) + k;
        if (idx >= num_in) idx = idx - num_in;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = idx[sel_w-1:0];
        end
      end
    end
  end

  // One-hot ready toward the granted channel, suppressed during reset.
  generate
    for (genvar i = 0; i < num_in; i++) begin : g_ready
      assign in_ready[i] = grant_valid & (grant == sel_w'(i)) & load_ok & ~reset;
    end
  endgenerate

  assign accept = |in_ready;

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*width +: width];
        out_sel   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Explicit wrap so non-power-of-two channel counts cycle correctly.
      if (accept && !force_en) begin
        ptr <= (grant == sel_w'(num_in-1)) ? '0 : grant + sel_w'(1);
      end
    end
  end

endmodule
`default_nettype wire
